// File: rtl/fifo_request_serializer_pkg.sv
// fifo_request_serializer_pkg: shared state encoding and field helpers for the wide-to-beat serializer.
package fifo_request_serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
  // The last flag sits directly above the beat payload in each queue entry.
  function automatic int last_flag_pos(input int beat_width);
    return beat_width;
  endfunction
endpackage

// File: rtl/fifo_request_serializer.sv
// fifo_request_serializer: captures one wide request per handshake and issues it as narrow beats with a last flag.
module fifo_request_serializer
  import fifo_request_serializer_pkg::*;
#(
  parameter int WIDE_WIDTH_IN_BITS     = 256,
  parameter int BEAT_WIDTH_IN_BITS     = 64,
  parameter int NUM_BEATS              = WIDE_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS,
  parameter int BEAT_CNT_WIDTH_IN_BITS = $clog2(NUM_BEATS)
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic [WIDE_WIDTH_IN_BITS-1:0]     request_in,
  input  logic [BEAT_CNT_WIDTH_IN_BITS-1:0] num_beats_in,
  input  logic                              request_valid_in,
  output logic                              issue_ack_out,
  output logic [BEAT_WIDTH_IN_BITS:0]       request_out,
  output logic                              request_valid_out,
  input  logic                              issue_ack_in,
  output logic                              busy_out
);
  localparam int LAST = last_flag_pos(BEAT_WIDTH_IN_BITS);
  localparam logic [BEAT_CNT_WIDTH_IN_BITS-1:0] MAX_LEN = BEAT_CNT_WIDTH_IN_BITS'(NUM_BEATS - 1);
  state_e                              state_q, state_d;
  logic [BEAT_CNT_WIDTH_IN_BITS-1:0]   cnt_q, cnt_d, len_q, len_d, len_in, cnt_nxt;
  logic [WIDE_WIDTH_IN_BITS-1:0]       req_q, req_d;
  logic [LAST:0]                       out_q, out_d;
  logic                                ack_q, ack_d, vld_q, vld_d;
  logic                                capture, beat_ack, last_beat;
  assign capture   = (state_q == IDLE) & request_valid_in & ~ack_q;
  assign beat_ack  = (state_q == SEND) & issue_ack_in;
  assign last_beat = cnt_q == len_q;
  assign len_in    = num_beats_in > MAX_LEN ? MAX_LEN : num_beats_in;
  assign cnt_nxt   = cnt_q + 1'b1;
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = capture ? SEND : (beat_ack & last_beat) ? IDLE : state_q;
  end
  // cnt_nxt is only used to index when the current beat is not the last, so it stays in range.
  always_comb begin
    req_d = capture ? request_in : req_q;
    len_d = capture ? len_in : len_q;
    cnt_d = capture ? '0 : (beat_ack & ~last_beat) ? cnt_nxt : cnt_q;
    ack_d = capture;
    vld_d = capture | (vld_q & ~(beat_ack & last_beat));
    out_d = capture ? {len_in == '0, request_in[BEAT_WIDTH_IN_BITS-1:0]}
          : !beat_ack ? out_q
          : last_beat ? '0
          : {cnt_nxt == len_q, req_q[int'(cnt_nxt)*BEAT_WIDTH_IN_BITS +: BEAT_WIDTH_IN_BITS]};
  end
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      req_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      out_q <= '0;
    end else begin
      req_q <= req_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      vld_q <= vld_d;
      out_q <= out_d;
    end
  assign issue_ack_out     = ack_q;
  assign request_valid_out = vld_q;
  assign request_out       = out_q;
  assign busy_out          = state_q == SEND;
endmodule

// File: tb/tb_fifo_request_serializer.sv
// tb_fifo_request_serializer: randomized bench with a queue-level reference model and a behavioural 16-entry downstream queue.
module tb_fifo_request_serializer;
  localparam int W = 256, B = 64, N = 4, CW = 2, QD = 16;
  logic          clk_in = 1'b0, reset_in = 1'b1;
  logic [W-1:0]  request_in = '0;
  logic [CW-1:0] num_beats_in = '0;
  logic          request_valid_in = 1'b0, issue_ack_in = 1'b0;
  logic          issue_ack_out, request_valid_out, busy_out;
  logic [B:0]    request_out;
  fifo_request_serializer dut (
    .clk_in(clk_in), .reset_in(reset_in), .request_in(request_in), .num_beats_in(num_beats_in),
    .request_valid_in(request_valid_in), .issue_ack_out(issue_ack_out), .request_out(request_out),
    .request_valid_out(request_valid_out), .issue_ack_in(issue_ack_in), .busy_out(busy_out)
  );
  always #5 clk_in = ~clk_in;
  int n_chk = 0, n_pass = 0;
  logic [B:0] m_beats[$], exp_q[$], fifo[$], popped[$];
  bit m_busy = 0, m_ack = 0, q_ack = 0, spur = 0, chk_on = 0, prev_ack = 0;
  int drain_period = 1, drain_cnt = 0, caps = 0, nb;
  logic [B:0] tmp;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
  endtask

  // Reference model: a capture turns the request into its list of tagged beats; each ack pops one.
  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      m_beats.delete(); exp_q.delete(); fifo.delete();
      m_busy = 0; m_ack = 0; q_ack = 0; drain_cnt = 0;
    end else begin
      if (!m_busy) begin
        if (request_valid_in && !m_ack) begin
          nb = (int'(num_beats_in) > N - 1 ? N - 1 : int'(num_beats_in)) + 1;
          for (int k = 0; k < nb; k++) begin
            tmp = {k == nb - 1, request_in[k*B +: B]};
            m_beats.push_back(tmp);
            exp_q.push_back(tmp);
          end
          m_busy = 1; m_ack = 1; caps++;
        end else m_ack = 0;
      end else begin
        m_ack = 0;
        if (issue_ack_in) begin
          void'(m_beats.pop_front());
          if (m_beats.size() == 0) m_busy = 0;
        end
      end
      if (request_valid_out && !q_ack && fifo.size() < QD) begin
        fifo.push_back(request_out);
        q_ack = 1;
      end else q_ack = 0;
      if (drain_period > 0) begin
        drain_cnt++;
        if (drain_cnt >= drain_period && fifo.size() > 0) begin
          drain_cnt = 0;
          tmp = fifo.pop_front();
          popped.push_back(tmp);
          if (exp_q.size() == 0) chk("stream_extra", tmp, 129'h0 - 1);
          else chk("stream", tmp, exp_q.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    #1 issue_ack_in = q_ack | (spur & ~m_busy);
  end

  always @(negedge clk_in) if (chk_on) begin
    chk("ack_out", issue_ack_out, m_ack);
    chk("valid_out", request_valid_out, m_busy);
    chk("req_out", request_out, m_busy ? m_beats[0] : '0);
    chk("busy_out", busy_out, m_busy);
    chk("ack_gap", issue_ack_out & prev_ack, 0);
    prev_ack = issue_ack_out;
  end

  function automatic logic [W-1:0] rnd_req();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_idle(input bit empty, input int lim);
    int i = 0;
    while ((m_busy || (empty && fifo.size() > 0)) && i < lim) begin
      @(negedge clk_in);
      i++;
    end
    chk("idle_timeout", i < lim, 1);
  endtask

  task automatic send(input logic [W-1:0] r, input int n);
    @(negedge clk_in);
    request_in = r; num_beats_in = n[CW-1:0]; request_valid_in = 1;
    @(negedge clk_in);
    request_valid_in = 0;
  endtask

  initial begin
    logic [W-1:0] r, r2;
    int c0, i;
    cyc(3);
    chk("reset_outs", {issue_ack_out, request_valid_out, busy_out, request_out}, 0);
    reset_in = 0;
    chk_on = 1;
    cyc(2);
    // four beats A..D, last flag only on D
    popped.delete();
    r = {64'hD, 64'hC, 64'hB, 64'hA};
    @(negedge clk_in);
    request_in = r; num_beats_in = 2'd3; request_valid_in = 1;
    @(negedge clk_in);
    request_valid_in = 0;
    chk("t1_beat0", request_out, {1'b0, 64'hA});
    chk("t1_ack", issue_ack_out, 1);
    @(negedge clk_in);
    chk("t1_ack_pulse", issue_ack_out, 0);
    wait_idle(1, 200);
    chk("t1_count", popped.size(), 4);
    chk("t1_first", popped[0], {1'b0, 64'hA});
    chk("t1_third", popped[2], {1'b0, 64'hC});
    chk("t1_last", popped[3], {1'b1, 64'hD});
    chk("t1_busy", busy_out, 0);
    // single beat: valid for exactly the capture cycle plus one write/ack round trip
    popped.delete();
    r = rnd_req();
    r[B-1:0] = 64'h1234;
    send(r, 0);
    chk("t2_beat", request_out, {1'b1, 64'h1234});
    chk("t2_busy0", busy_out, 1);
    @(negedge clk_in);
    chk("t2_busy1", busy_out, 1);
    @(negedge clk_in);
    chk("t2_idle", busy_out, 0);
    chk("t2_valid", request_valid_out, 0);
    wait_idle(1, 50);
    chk("t2_count", popped.size(), 1);
    // queue almost full with a slow consumer
    drain_period = 0;
    cyc(1);
    for (i = 0; i < QD - 1; i++) begin
      tmp = {1'b0, 32'h0, $urandom};
      fifo.push_back(tmp);
      exp_q.push_back(tmp);
    end
    drain_cnt = 0;
    drain_period = 10;
    send(rnd_req(), 3);
    wait_idle(1, 400);
    // valid held high across two requests
    drain_period = 1;
    r = rnd_req(); r2 = rnd_req();
    c0 = caps;
    @(negedge clk_in);
    request_in = r; num_beats_in = 2'd1; request_valid_in = 1;
    i = 0;
    while (caps < c0 + 2 && i < 200) begin
      @(negedge clk_in);
      if (caps == c0 + 1) begin request_in = r2; num_beats_in = 2'd2; end
      i++;
    end
    request_valid_in = 0;
    chk("t4_captures", caps - c0, 2);
    wait_idle(1, 100);
    // reset after the first of four beats is accepted
    send(rnd_req(), 3);
    i = 0;
    while (m_beats.size() != 3 && i < 50) begin @(negedge clk_in); i++; end
    chk("t5_reach_beat1", m_beats.size(), 3);
    #2 reset_in = 1;
    #1 chk("t5_async_zero", {issue_ack_out, request_valid_out, busy_out, request_out}, 0);
    @(negedge clk_in);
    reset_in = 0;
    popped.delete();
    send(rnd_req(), 1);
    wait_idle(1, 100);
    chk("t5_count", popped.size(), 2);
    chk("t5_last", popped[1][B], 1);
    // spurious acks while idle
    c0 = caps;
    repeat (8) begin
      @(negedge clk_in);
      spur = 1'($urandom_range(0, 1));
    end
    @(negedge clk_in);
    spur = 0;
    chk("t6_no_capture", caps - c0, 0);
    chk("t6_busy", busy_out, 0);
    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      drain_period = $urandom_range(1, 4);
      cyc($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) wait_idle(0, 200);
      send(rnd_req(), $urandom_range(0, 3));
    end
    drain_period = 1;
    wait_idle(1, 500);
    chk("end_stream_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
